// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM read port, decode-side valid/ready handshake and jump redirect.
interface instr_fetch_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 16
);
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_addr;
   logic                  rom_en;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_data;
   logic                  instr_valid;
   logic [DATA_WIDTH-1:0] instr;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic                  instr_ready;

   modport master (
      input  redirect, redirect_addr, rom_data, instr_ready,
      output rom_en, rom_addr, instr_valid, instr, instr_pc
   );

   modport slave (
      output redirect, redirect_addr, rom_data, instr_ready,
      input  rom_en, rom_addr, instr_valid, instr, instr_pc
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues reads to a 1-cycle synchronous ROM, buffers
// returned words with their addresses and hands them to decode over valid/ready.
module instr_fetch #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   instr_fetch_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = CW + 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] issued_pc;
   logic                  inflight;
   logic [CW-1:0]         count;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data [DEPTH];

   logic                  pop;
   logic                  push;
   logic                  issue;
   logic [OW-1:0]         occupancy;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Occupancy counts the in-flight read so a slot is always reserved for it.
   always_comb begin
      pop       = (count != '0) && bus.instr_ready;
      occupancy = OW'(count) + OW'(inflight) - OW'(pop);
      issue     = reset_n && !bus.redirect && (occupancy < OW'(DEPTH));
      push      = inflight && !bus.redirect;
   end

   assign bus.rom_en      = issue;
   assign bus.rom_addr    = fetch_pc;
   assign bus.instr_valid = (count != '0);
   assign bus.instr       = mem_data[rd_ptr];
   assign bus.instr_pc    = mem_addr[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc  <= '0;
         issued_pc <= '0;
         inflight  <= 1'b0;
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_addr[i] <= '0;
            mem_data[i] <= '0;
         end
      end else if (bus.redirect) begin
         // Flush dominates any coincident pop; the returning ROM word is dropped.
         fetch_pc <= bus.redirect_addr;
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            fetch_pc  <= fetch_pc + ADDR_WIDTH'(1);
            issued_pc <= fetch_pc;
         end
         if (push) begin
            mem_addr[wr_ptr] <= issued_pc;
            mem_data[wr_ptr] <= bus.rom_data;
            wr_ptr           <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run against a
// queue-based model of issued-but-undelivered fetches.
module tb_instr_fetch;
   localparam int AW    = 15;
   localparam int DW    = 16;
   localparam int DEPTH = 2;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   n_vec   = 0;
   int   n_err   = 0;

   instr_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   instr_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      return {1'b0, a} ^ 16'hA5A5;
   endfunction

   always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom_word(bus.rom_addr);

   // Model: every issued read is an entry that becomes visible two cycles later
   // and leaves when consumed or flushed.
   typedef struct { logic [AW-1:0] pc; int avail; } ent_t;
   ent_t          q[$];
   logic [AW-1:0] mpc = '0;
   int            cyc = 0;

   function automatic logic m_valid();
      return (q.size() != 0) && (q[0].avail <= cyc);
   endfunction

   function automatic logic m_en();
      int p;
      p = (m_valid() && bus.instr_ready) ? 1 : 0;
      return reset_n && !bus.redirect && ((q.size() - p) < DEPTH);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         mpc = '0;
         cyc = 0;
      end else begin
         logic v, e;
         v = m_valid();
         e = m_en();
         if (bus.redirect) begin
            q.delete();
            mpc = bus.redirect_addr;
         end else begin
            if (v && bus.instr_ready) void'(q.pop_front());
            if (e) begin
               q.push_back('{mpc, cyc + 2});
               mpc = mpc + 1'b1;
            end
         end
         cyc++;
      end
   end

   task automatic tick(input logic rd, input logic [AW-1:0] ra, input logic rdy);
      @(negedge clk);
      bus.redirect      = rd;
      bus.redirect_addr = ra;
      bus.instr_ready   = rdy;
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      @(negedge clk);
      reset_n           = 1'b0;
      bus.redirect      = 1'b0;
      bus.redirect_addr = '0;
      bus.instr_ready   = rdy;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n           = 1'b0;
      bus.redirect      = 1'b0;
      bus.redirect_addr = '0;
      bus.instr_ready   = 1'b1;
      #1;
      n_vec += 4;
      if (bus.rom_en !== 1'b0) begin n_err++; $display("FAIL reset_rom_en got %b want 0", bus.rom_en); end
      if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
      if (bus.instr !== 16'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", bus.instr); end
      if (bus.instr_pc !== 15'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", bus.instr_pc); end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_vec++;
      if (bus.rom_en !== 1'b1 || bus.rom_addr !== 15'h0) begin
         n_err++; $display("FAIL reset_first_issue got en=%b addr=%h want en=1 addr=0", bus.rom_en, bus.rom_addr);
      end
   endtask

   task automatic test_stream();
      do_reset(1'b1);
      for (int k = 0; k < 16; k++) begin
         if (k > 0) tick(1'b0, '0, 1'b1);
         n_vec += 2;
         if (bus.rom_en !== 1'b1 || bus.rom_addr !== AW'(k)) begin
            n_err++; $display("FAIL stream_issue cyc %0d got en=%b addr=%h want en=1 addr=%h", k, bus.rom_en, bus.rom_addr, AW'(k));
         end
         if (bus.instr_valid !== (k >= 2)) begin
            n_err++; $display("FAIL stream_valid cyc %0d got %b want %b", k, bus.instr_valid, (k >= 2));
         end
         if (k == 2) begin
            n_vec++;
            if (bus.instr_pc !== 15'h0 || bus.instr !== 16'hA5A5) begin
               n_err++; $display("FAIL stream_first got pc=%h instr=%h want pc=0 instr=a5a5", bus.instr_pc, bus.instr);
            end
         end else if (k > 2) begin
            n_vec++;
            if (bus.instr_pc !== AW'(k - 2) || bus.instr !== rom_word(AW'(k - 2))) begin
               n_err++; $display("FAIL stream_word cyc %0d got pc=%h instr=%h want pc=%h instr=%h", k, bus.instr_pc, bus.instr, AW'(k - 2), rom_word(AW'(k - 2)));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] issued[$];
      logic [AW-1:0] got[$];
      logic [AW-1:0] first_resume;
      logic          resumed;
      resumed = 1'b0;
      first_resume = '1;
      do_reset(1'b0);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick(1'b0, '0, 1'b0);
         if (bus.rom_en) issued.push_back(bus.rom_addr);
      end
      n_vec += 2;
      if (issued.size() != DEPTH || issued[0] !== 15'd0 || issued[1] !== 15'd1) begin
         n_err++; $display("FAIL bp_issue_count got %0d reads want 2 (addr 0,1)", issued.size());
      end
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 15'd0) begin
         n_err++; $display("FAIL bp_head got valid=%b pc=%h want valid=1 pc=0", bus.instr_valid, bus.instr_pc);
      end
      for (int k = 0; k < 10; k++) begin
         tick(1'b0, '0, 1'b1);
         if (bus.rom_en && !resumed) begin resumed = 1'b1; first_resume = bus.rom_addr; end
         if (bus.instr_valid) begin
            got.push_back(bus.instr_pc);
            n_vec++;
            if (bus.instr !== rom_word(bus.instr_pc)) begin
               n_err++; $display("FAIL bp_data pc %h got %h want %h", bus.instr_pc, bus.instr, rom_word(bus.instr_pc));
            end
         end
      end
      n_vec += 2;
      if (first_resume !== 15'd2) begin
         n_err++; $display("FAIL bp_resume_addr got %h want 2", first_resume);
      end
      if (got.size() != 10) begin
         n_err++; $display("FAIL bp_delivered_count got %0d want 10", got.size());
      end
      for (int i = 0; i < got.size(); i++) begin
         n_vec++;
         if (got[i] !== AW'(i)) begin n_err++; $display("FAIL bp_order idx %0d got %h want %h", i, got[i], AW'(i)); end
      end
   endtask

   task automatic test_redirect_inflight();
      logic [AW-1:0] got[$];
      logic [AW-1:0] exp_pc[9];
      exp_pc = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd4, 15'h100, 15'h101, 15'h102, 15'h103};
      do_reset(1'b1);
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) tick(k == 6, (k == 6) ? 15'h100 : 15'h0, 1'b1);
         if (k == 6) begin
            n_vec++;
            if (bus.rom_en !== 1'b0) begin n_err++; $display("FAIL redir_en_low got %b want 0", bus.rom_en); end
         end
         if (k == 7) begin
            n_vec++;
            if (bus.rom_en !== 1'b1 || bus.rom_addr !== 15'h100) begin
               n_err++; $display("FAIL redir_target_issue got en=%b addr=%h want en=1 addr=100", bus.rom_en, bus.rom_addr);
            end
         end
         if (k == 8) begin
            n_vec++;
            if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble got valid=%b want 0", bus.instr_valid); end
         end
         if (bus.instr_valid) got.push_back(bus.instr_pc);
      end
      n_vec++;
      if (got.size() != 9) begin
         n_err++; $display("FAIL redir_count got %0d want 9", got.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (got[i] !== exp_pc[i]) begin n_err++; $display("FAIL redir_order idx %0d got %h want %h", i, got[i], exp_pc[i]); end
         end
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] got[$];
      do_reset(1'b1);
      tick(1'b0, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      tick(1'b1, 15'h7FFF, 1'b1);
      for (int k = 0; k < 8; k++) begin
         tick(1'b0, '0, 1'b1);
         if (bus.instr_valid) got.push_back(bus.instr_pc);
      end
      n_vec++;
      if (got.size() < 3) begin
         n_err++; $display("FAIL wrap_count got %0d want >=3", got.size());
      end else begin
         n_vec += 3;
         if (got[0] !== 15'h7FFF) begin n_err++; $display("FAIL wrap_pc0 got %h want 7fff", got[0]); end
         if (got[1] !== 15'h0000) begin n_err++; $display("FAIL wrap_pc1 got %h want 0000", got[1]); end
         if (got[2] !== 15'h0001) begin n_err++; $display("FAIL wrap_pc2 got %h want 0001", got[2]); end
      end
   endtask

   task automatic test_redirect_full();
      do_reset(1'b0);
      for (int k = 0; k < 4; k++) tick(1'b0, '0, 1'b0);
      n_vec++;
      if (bus.instr_valid !== 1'b1 || bus.rom_en !== 1'b0) begin
         n_err++; $display("FAIL full_stall got valid=%b en=%b want valid=1 en=0", bus.instr_valid, bus.rom_en);
      end
      tick(1'b1, 15'h2A0, 1'b1);
      n_vec++;
      if (bus.instr_valid !== 1'b1 || bus.rom_en !== 1'b0) begin
         n_err++; $display("FAIL full_redir_cycle got valid=%b en=%b want valid=1 en=0", bus.instr_valid, bus.rom_en);
      end
      tick(1'b0, '0, 1'b1);
      n_vec++;
      if (bus.instr_valid !== 1'b0 || bus.rom_en !== 1'b1 || bus.rom_addr !== 15'h2A0) begin
         n_err++; $display("FAIL full_flush got valid=%b en=%b addr=%h want valid=0 en=1 addr=2a0", bus.instr_valid, bus.rom_en, bus.rom_addr);
      end
      tick(1'b0, '0, 1'b1);
      n_vec++;
      if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL full_latency got valid=%b want 0", bus.instr_valid); end
      tick(1'b0, '0, 1'b1);
      n_vec++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 15'h2A0 || bus.instr !== rom_word(15'h2A0)) begin
         n_err++; $display("FAIL full_target got valid=%b pc=%h instr=%h want valid=1 pc=2a0 instr=%h", bus.instr_valid, bus.instr_pc, bus.instr, rom_word(15'h2A0));
      end
   endtask

   task automatic test_async_reset();
      do_reset(1'b1);
      for (int k = 0; k < 5; k++) tick(1'b0, '0, 1'b1);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      n_vec++;
      if (bus.instr_valid !== 1'b0 || bus.rom_en !== 1'b0 || bus.instr_pc !== 15'h0) begin
         n_err++; $display("FAIL async_clear got valid=%b en=%b pc=%h want 0 0 0", bus.instr_valid, bus.rom_en, bus.instr_pc);
      end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_vec++;
      if (bus.rom_en !== 1'b1 || bus.rom_addr !== 15'h0) begin
         n_err++; $display("FAIL async_restart got en=%b addr=%h want en=1 addr=0", bus.rom_en, bus.rom_addr);
      end
      tick(1'b0, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      n_vec++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 15'h0 || bus.instr !== 16'hA5A5) begin
         n_err++; $display("FAIL async_first got valid=%b pc=%h instr=%h want 1 0 a5a5", bus.instr_valid, bus.instr_pc, bus.instr);
      end
   endtask

   task automatic test_random();
      logic          rd;
      logic          rdy;
      logic [AW-1:0] ra;
      do_reset(1'b1);
      for (int k = 0; k < 600; k++) begin
         rd  = ($urandom_range(0, 9) == 0);
         ra  = ($urandom_range(0, 3) == 0) ? AW'(15'h7FFE + $urandom_range(0, 1)) : AW'($urandom);
         rdy = ($urandom_range(0, 3) != 0);
         tick(rd, ra, rdy);
         n_vec += 2;
         if (bus.rom_en !== m_en()) begin
            n_err++; $display("FAIL rand_en cyc %0d got %b want %b", k, bus.rom_en, m_en());
         end else if (bus.rom_en && bus.rom_addr !== mpc) begin
            n_err++; $display("FAIL rand_addr cyc %0d got %h want %h", k, bus.rom_addr, mpc);
         end
         if (bus.instr_valid !== m_valid()) begin
            n_err++; $display("FAIL rand_valid cyc %0d got %b want %b", k, bus.instr_valid, m_valid());
         end else if (m_valid()) begin
            n_vec++;
            if (bus.instr_pc !== q[0].pc || bus.instr !== rom_word(q[0].pc)) begin
               n_err++; $display("FAIL rand_head cyc %0d got pc=%h instr=%h want pc=%h instr=%h", k, bus.instr_pc, bus.instr, q[0].pc, rom_word(q[0].pc));
            end
         end
      end
   endtask

   initial begin
      bus.redirect      = 1'b0;
      bus.redirect_addr = '0;
      bus.instr_ready   = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_inflight();
      test_wrap();
      test_redirect_full();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch front end on the consumer side of the program counter.
- Owns a fetch address and reads a synchronous instruction ROM (1-cycle read latency).
- Buffers returned words with their addresses in a small FIFO and presents them to the CPU decode stage over a valid/ready handshake.
- Taken jumps redirect fetch: the buffer and any in-flight read are flushed.

Parameters:
- ADDR_WIDTH, 15, ROM word-address width; fetch address wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 16, instruction width.
- DEPTH, 2, FIFO entries; legal values ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- redirect  in  1  jump taken; restart fetch at redirect_addr.
- redirect_addr  in  ADDR_WIDTH  jump target.
- rom_en  out  1  ROM read request this cycle.
- rom_addr  out  ADDR_WIDTH  ROM read address; meaningful only when rom_en=1.
- rom_data  in  DATA_WIDTH  ROM word; valid in the cycle after the rom_en cycle.
- instr_valid  out  1  head FIFO entry available.
- instr  out  DATA_WIDTH  head instruction.
- instr_pc  out  ADDR_WIDTH  address of head instruction.
- instr_ready  in  1  consumer accepts head entry.

Behaviour:
- Reset (reset_n=0, takes effect immediately):
  - fetch_pc=0, FIFO empty, inflight=0.
  - rom_en=0, instr_valid=0, instr=0, instr_pc=0.
- State:
  - fetch_pc (ADDR_WIDTH).
  - inflight (1 bit): read issued last cycle.
  - FIFO count (0..DEPTH) with DEPTH entries of {addr, data}.
- Pop:
  - pop = instr_valid & instr_ready.
  - instr_valid = (count != 0).
  - instr and instr_pc come from the head entry, registered. No combinational path from rom_data to instr.
- Issue (no redirect this cycle):
  - rom_en = 1 when count + inflight - pop < DEPTH.
  - rom_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc + 1, wrapping from 2^ADDR_WIDTH-1 to 0; inflight <= 1. Otherwise inflight <= 0.
- Return:
  - When inflight=1 and no redirect in that cycle, push {address issued last cycle, rom_data} at the cycle's end.
  - Latency: rom_en in cycle N → instr_valid earliest in cycle N+2.
- Throughput with DEPTH=2 and instr_ready held high: one instruction per cycle in steady state.
- Push and pop in the same cycle: count is unchanged and order is preserved.
- Redirect (redirect=1 in a cycle):
  - rom_en=0 that cycle.
  - At the edge: FIFO emptied (count=0), inflight <= 0, so the returning rom_data is discarded. fetch_pc <= redirect_addr.
  - The next cycle issues redirect_addr; its instruction is valid 2 cycles after that.
  - A pop coincident with redirect counts as a completed handshake, but the flush dominates the count update.
  - redirect on consecutive cycles: the last target wins; no issue occurs until redirect deasserts.
- Full FIFO with instr_ready=0: rom_en=0, all state holds, outputs stable.
- The FIFO never overflows: the issue rule reserves a slot for every in-flight read.
- reset_n asserted mid-operation: immediate clear as above. After release, the first rising edge issues address 0.

Test Plan:
- Reset then stream:
  - Stimulus: ROM[a]=a^16'hA5A5, instr_ready=1.
  - Required: rom_en=1/rom_addr=0 in cycle 0. instr_valid first in cycle 2 with instr_pc=0, instr=16'hA5A5. Then instr_pc 1,2,3,… on consecutive cycles, with no bubbles.
- Backpressure:
  - Stimulus: instr_ready=0 from cycle 0.
  - Required: exactly DEPTH=2 reads issued (addr 0,1), then rom_en=0 and fetch_pc=2. Raise instr_ready: entries for addr 0 then 1 delivered, fetching resumes at 2, no word lost or duplicated.
- Redirect with read in flight:
  - Stimulus: streaming; assert redirect with redirect_addr=0x100 in the cycle rom_data for addr 5 returns.
  - Required: addr 5 never appears on instr. Next cycle rom_addr=0x100; instr_pc=0x100 valid 2 cycles later, followed by 0x101.
- Wrap-around:
  - Stimulus: redirect_addr=0x7FFF.
  - Required: delivered instr_pc sequence 0x7FFF, 0x0000, 0x0001.
- Redirect + pop + full:
  - Stimulus: FIFO full, instr_ready=1 and redirect=1 in the same cycle.
  - Required: count=0 next cycle, instr_valid=0, then a fresh fetch from the target.
- Async reset mid-stream:
  - Stimulus: drop reset_n between edges.
  - Required: instr_valid and rom_en go 0 immediately. After release, fetch restarts at addr 0.
